// File: rtl/simply5_pkg.sv
// Shared constants for the simply5 decode path: datapath width, opcode values
// and RV32 instruction field bit positions.
package simply5_pkg;

    localparam int REGISTER_SIZE = 32;
    localparam int REG_COUNT     = 32;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port. x0 always reads zero and ignores writes.
module reg_file #(
    parameter int REGISTER_SIZE = 32,
    parameter int REG_COUNT     = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [4:0]               rs1_i,
    input  logic [4:0]               rs2_i,
    output logic [REGISTER_SIZE-1:0] rs1_data_o,
    output logic [REGISTER_SIZE-1:0] rs2_data_o,
    input  logic                     we_i,
    input  logic [4:0]               wa_i,
    input  logic [REGISTER_SIZE-1:0] wd_i
);

    logic [REGISTER_SIZE-1:0] regs_q [REG_COUNT];

    // Storage write; reset clears every register, x0 is never written.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0) && (int'(wa_i) < REG_COUNT)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Combinational read ports with x0 and out-of-range forced to zero.
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if ((rs1_i != 5'd0) && (int'(rs1_i) < REG_COUNT)) begin
            rs1_data_o = regs_q[rs1_i];
        end
        if ((rs2_i != 5'd0) && (int'(rs2_i) < REG_COUNT)) begin
            rs2_data_o = regs_q[rs2_i];
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits R-type instructions into fields, reads operands with
// writeback bypass, tracks in-flight destinations in a busy scoreboard and
// holds the result in a single-entry valid/ready output register.
module decode_stage #(
    parameter int REGISTER_SIZE = simply5_pkg::REGISTER_SIZE,
    parameter int REG_COUNT     = simply5_pkg::REG_COUNT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              inst_i,
    input  logic                     inst_valid_i,
    output logic                     inst_ready_o,
    input  logic                     wb_en_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [REGISTER_SIZE-1:0] wb_data_i,
    input  logic                     flush_i,
    output logic [REGISTER_SIZE-1:0] data1_o,
    output logic [REGISTER_SIZE-1:0] data2_o,
    output logic [6:0]               opcode_o,
    output logic [2:0]               func3_o,
    output logic [6:0]               func7_o,
    output logic [4:0]               rd_o,
    output logic                     illegal_o,
    output logic                     valid_o,
    input  logic                     ready_i
);

    import simply5_pkg::*;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] func3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] func7;
    logic       is_rtype;

    assign opcode   = inst_i[OPC_MSB:OPC_LSB];
    assign rd       = inst_i[RD_MSB:RD_LSB];
    assign func3    = inst_i[F3_MSB:F3_LSB];
    assign rs1      = inst_i[RS1_MSB:RS1_LSB];
    assign rs2      = inst_i[RS2_MSB:RS2_LSB];
    assign func7    = inst_i[F7_MSB:F7_LSB];
    assign is_rtype = (opcode == OP_RTYPE);

    logic [REGISTER_SIZE-1:0] rf_rs1_data;
    logic [REGISTER_SIZE-1:0] rf_rs2_data;

    reg_file #(
        .REGISTER_SIZE(REGISTER_SIZE),
        .REG_COUNT    (REG_COUNT)
    ) u_reg_file (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rs1_i     (rs1),
        .rs2_i     (rs2),
        .rs1_data_o(rf_rs1_data),
        .rs2_data_o(rf_rs2_data),
        .we_i      (wb_en_i),
        .wa_i      (wb_rd_i),
        .wd_i      (wb_data_i)
    );

    logic [REG_COUNT-1:0]     busy_q, busy_d;
    logic                     valid_q, valid_d;
    logic [REGISTER_SIZE-1:0] data1_q, data1_d;
    logic [REGISTER_SIZE-1:0] data2_q, data2_d;
    logic [6:0]               opcode_q, opcode_d;
    logic [2:0]               func3_q, func3_d;
    logic [6:0]               func7_q, func7_d;
    logic [4:0]               rd_q, rd_d;
    logic                     illegal_q, illegal_d;

    logic [REG_COUNT-1:0]     wb_clr;
    logic [REG_COUNT-1:0]     busy_eff;
    logic                     hazard;
    logic                     accept;
    logic [REGISTER_SIZE-1:0] op1;
    logic [REGISTER_SIZE-1:0] op2;

    // Hazard detection against the scoreboard, discounting bits this cycle's writeback releases.
    always_comb begin
        wb_clr = '0;
        if (wb_en_i && (wb_rd_i != 5'd0)) begin
            wb_clr[wb_rd_i] = 1'b1;
        end
        busy_eff = busy_q & ~wb_clr;
        hazard   = is_rtype && (((rs1 != 5'd0) && busy_eff[rs1]) ||
                                ((rs2 != 5'd0) && busy_eff[rs2]) ||
                                ((rd  != 5'd0) && busy_eff[rd]));
        inst_ready_o = !rst_i && (!valid_q || ready_i) && !hazard && !flush_i;
        accept       = inst_valid_i && inst_ready_o;
    end

    // Operand select: same-cycle writeback bypasses the register file; illegal ops get zeros.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (is_rtype) begin
            op1 = (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1)) ? wb_data_i : rf_rs1_data;
            op2 = (wb_en_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2)) ? wb_data_i : rf_rs2_data;
        end
    end

    // Next-state for scoreboard and output register; flush beats accept and consumption.
    always_comb begin
        busy_d    = busy_q & ~wb_clr;
        valid_d   = valid_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        opcode_d  = opcode_q;
        func3_d   = func3_q;
        func7_d   = func7_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;

        if (flush_i) begin
            valid_d = 1'b0;
            if (valid_q && !illegal_q && (rd_q != 5'd0)) begin
                busy_d[rd_q] = 1'b0;
            end
        end else if (accept) begin
            valid_d   = 1'b1;
            data1_d   = op1;
            data2_d   = op2;
            opcode_d  = opcode;
            func3_d   = func3;
            func7_d   = func7;
            rd_d      = rd;
            illegal_d = !is_rtype;
            // Setting after the writeback clear lets a same-rd accept win.
            if (is_rtype && (rd != 5'd0)) begin
                busy_d[rd] = 1'b1;
            end
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset empties the output slot and the scoreboard.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q    <= '0;
            valid_q   <= 1'b0;
            data1_q   <= '0;
            data2_q   <= '0;
            opcode_q  <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            opcode_q  <= opcode_d;
            func3_q   <= func3_d;
            func7_q   <= func7_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o   = valid_q;
    assign data1_o   = data1_q;
    assign data2_o   = data2_q;
    assign opcode_o  = opcode_q;
    assign func3_o   = func3_q;
    assign func7_o   = func7_q;
    assign rd_o      = rd_q;
    assign illegal_o = illegal_q;

endmodule
